// File: rtl/ks_pkg.sv
// Shared elaboration helpers for the pipelined Kogge-Stone adder:
// prefix level count, pipeline stage count and register placement.
package ks_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Prefix level count L for a given operand width.
   function automatic int ks_levels(input int width);
      return clog2(width);
   endfunction

   // Register stages after the pre-process register: NSTG = ceil(L / PIPE_EVERY).
   function automatic int ks_stages(input int width, input int pipe_every);
      return (ks_levels(width) + pipe_every - 1) / pipe_every;
   endfunction

   // The last level always gets a register because it doubles as the output register.
   function automatic bit is_reg_level(input int k, input int levels, input int pipe_every);
      return (((k + 1) % pipe_every) == 0) || (k == levels - 1);
   endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone black cell: combines a high (G,P) group with the adjacent
// low group into one wider (G,P) group.
module ks_prefix_cell
   import ks_pkg::*;
(
   input  logic gh,
   input  logic ph,
   input  logic gl,
   input  logic pl,
   output logic g,
   output logic p
);

   assign g = gh | (ph & gl);
   assign p = ph & pl;

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined WIDTH-bit Kogge-Stone adder with valid/ready handshake.
// Optional macro KS_ADD_SUB_EN adds a per-transaction 'sub' port (a - b).
module ks_pipe_adder
   import ks_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int PIPE_EVERY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef KS_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int L = ks_levels(WIDTH);

   // Index k of these arrays is the input to prefix level k; index L is the output register.
   logic [WIDTH-1:0] g_lvl  [L+1];
   logic [WIDTH-1:0] p_lvl  [L];
   logic [WIDTH-1:0] po_lvl [L+1];
   logic             c_lvl  [L+1];
   logic             v_lvl  [L+1];

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [WIDTH-1:0] g_pre;
   logic [WIDTH-1:0] p_pre;
   logic             v0_d, v0_q;
   logic             c0_d, c0_q;
   logic [WIDTH-1:0] g0_d, g0_q;
   logic [WIDTH-1:0] p0_d, p0_q;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_comb begin
`ifdef KS_ADD_SUB_EN
      b_eff   = sub ? ~b : b;
      cin_eff = sub | cin;
`else
      b_eff   = b;
      cin_eff = cin;
`endif
      p_pre    = a ^ b_eff;
      g_pre    = a & b_eff;
      // Carry-in is absorbed into bit 0 so the prefix tree yields true carries directly.
      g_pre[0] = g_pre[0] | (p_pre[0] & cin_eff);
      v0_d     = adv ? in_valid : v0_q;
      c0_d     = adv ? cin_eff  : c0_q;
      g0_d     = adv ? g_pre    : g0_q;
      p0_d     = adv ? p_pre    : p0_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q <= 1'b0;
         c0_q <= 1'b0;
         g0_q <= '0;
         p0_q <= '0;
      end else begin
         v0_q <= v0_d;
         c0_q <= c0_d;
         g0_q <= g0_d;
         p0_q <= p0_d;
      end
   end

   assign v_lvl[0]  = v0_q;
   assign c_lvl[0]  = c0_q;
   assign g_lvl[0]  = g0_q;
   assign p_lvl[0]  = p0_q;
   assign po_lvl[0] = p0_q;

   genvar gk, gi;
   generate
      for (gk = 0; gk < L; gk++) begin : g_level
         localparam int SPAN   = 1 << gk;
         localparam bit IS_REG = is_reg_level(gk, L, PIPE_EVERY);

         logic [WIDTH-1:0] g_nxt;

         if (gk < L - 1) begin : g_black
            logic [WIDTH-1:0] p_nxt;

            for (gi = 0; gi < WIDTH; gi++) begin : g_pos
               if (gi < SPAN) begin : g_pass
                  assign g_nxt[gi] = g_lvl[gk][gi];
                  assign p_nxt[gi] = p_lvl[gk][gi];
               end else begin : g_cell
                  ks_prefix_cell u_cell (
                     .gh (g_lvl[gk][gi]),
                     .ph (p_lvl[gk][gi]),
                     .gl (g_lvl[gk][gi-SPAN]),
                     .pl (p_lvl[gk][gi-SPAN]),
                     .g  (g_nxt[gi]),
                     .p  (p_nxt[gi])
                  );
               end
            end

            if (IS_REG) begin : g_preg
               logic [WIDTH-1:0] p_d, p_q;

               always_comb p_d = adv ? p_nxt : p_q;

               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n) p_q <= '0;
                  else        p_q <= p_d;
               end

               assign p_lvl[gk+1] = p_q;
            end else begin : g_pwire
               assign p_lvl[gk+1] = p_nxt;
            end
         end else begin : g_grey
            // Final level: group propagate has no consumer, so only G is formed.
            for (gi = 0; gi < WIDTH; gi++) begin : g_pos
               if (gi < SPAN) begin : g_pass
                  assign g_nxt[gi] = g_lvl[gk][gi];
               end else begin : g_cell
                  assign g_nxt[gi] = g_lvl[gk][gi] | (p_lvl[gk][gi] & g_lvl[gk][gi-SPAN]);
               end
            end
         end

         if (IS_REG) begin : g_reg
            logic             v_d, v_q;
            logic             c_d, c_q;
            logic [WIDTH-1:0] g_d, g_q;
            logic [WIDTH-1:0] po_d, po_q;

            always_comb begin
               v_d  = adv ? v_lvl[gk]  : v_q;
               c_d  = adv ? c_lvl[gk]  : c_q;
               g_d  = adv ? g_nxt      : g_q;
               po_d = adv ? po_lvl[gk] : po_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  v_q  <= 1'b0;
                  c_q  <= 1'b0;
                  g_q  <= '0;
                  po_q <= '0;
               end else begin
                  v_q  <= v_d;
                  c_q  <= c_d;
                  g_q  <= g_d;
                  po_q <= po_d;
               end
            end

            assign v_lvl[gk+1]  = v_q;
            assign c_lvl[gk+1]  = c_q;
            assign g_lvl[gk+1]  = g_q;
            assign po_lvl[gk+1] = po_q;
         end else begin : g_wire
            assign v_lvl[gk+1]  = v_lvl[gk];
            assign c_lvl[gk+1]  = c_lvl[gk];
            assign g_lvl[gk+1]  = g_nxt;
            assign po_lvl[gk+1] = po_lvl[gk];
         end
      end
   endgenerate

   logic [WIDTH-1:0] carry_in;

   // Bit i sees the carry out of bit i-1; bit 0 sees the (effective) carry-in.
   assign carry_in  = {g_lvl[L][WIDTH-2:0], c_lvl[L]};
   assign out_valid = v_lvl[L];
   assign sum       = out_valid ? (po_lvl[L] ^ carry_in) : '0;
   assign cout      = out_valid & g_lvl[L][WIDTH-1];
   assign ovf       = out_valid & (g_lvl[L][WIDTH-1] ^ g_lvl[L][WIDTH-2]);

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Directed/scoreboard bench for ks_pipe_adder (WIDTH=16, PIPE_EVERY=2).
// Subtract cases are exercised when KS_ADD_SUB_EN is defined.
module tb_ks_pipe_adder;

   localparam int W   = 16;
   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks   = 0;
   int failures = 0;
   int n_out    = 0;

   // Scoreboard entries are {cout, ovf, sum}.
   logic [W+1:0] sb [$];

   always #5 clk = ~clk;

   ks_pipe_adder #(.WIDTH(W), .PIPE_EVERY(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef KS_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
      logic [W-1:0] yy;
      logic         c;
      logic [W:0]   full;
      logic         v;
      yy   = s ? ~y : y;
      c    = s ? 1'b1 : ci;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
      v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
      return {full[W], v, full[W-1:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
      a        = x;
      b        = y;
      cin      = ci;
      sub      = s;
      in_valid = 1'b1;
   endtask

   task automatic send_wait(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic s,
                            input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
      int lat;
      drive(x, y, ci, s);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"},  lat,  LAT);
      chk({tag, "_sum"},  sum,  e_sum);
      chk({tag, "_cout"}, cout, e_cout);
      chk({tag, "_ovf"},  ovf,  e_ovf);
      $display("txn %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               tag, x, y, ci, s, sum, cout, ovf, lat);
      tick();
   endtask

   // Output scoreboard and input capture, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            n_out++;
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               logic [W+1:0] e;
               e = sb.pop_front();
               chk("out_data", {cout, ovf, sum}, e);
               $display("out #%0d sum=%h cout=%0d ovf=%0d exp=%h", n_out, sum, cout, ovf, e);
            end
         end
         if (in_valid && in_ready) sb.push_back(model(a, b, cin, sub));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "FAIL watchdog");
   end

   initial begin
      int n0;
      int idx;
      logic acc;
      logic s_r;
      logic [W-1:0] bpa [8];
      logic [W-1:0] bpb [8];
      logic         bpc [8];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum",       sum,       0);
      chk("rst_cout",      cout,      0);
      chk("rst_ovf",       ovf,       0);
      chk("rst_in_ready",  in_ready,  1);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);

      send_wait("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      send_wait("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send_wait("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      send_wait("cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
`ifdef KS_ADD_SUB_EN
      send_wait("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send_wait("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      send_wait("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

      // Back-to-back stream: results on consecutive cycles starting at LAT.
      n0 = n_out;
      for (int i = 1; i <= 12; i++) begin
         if (i <= 8) begin
            s_r = 1'b0;
`ifdef KS_ADD_SUB_EN
            s_r = 1'($urandom_range(0, 1));
`endif
            drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), s_r);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         chk("stream_valid", out_valid, (i >= LAT && i <= 8 + LAT - 1));
      end
      chk("stream_count", n_out - n0, 8);

      // Backpressure: out_ready low for 4 cycles mid-stream.
      for (int i = 0; i < 8; i++) begin
         bpa[i] = 16'($urandom);
         bpb[i] = 16'($urandom);
         bpc[i] = 1'($urandom_range(0, 1));
      end
      n0 = n_out;
      idx = 0;
      for (int step = 0; step < 40 && !(idx == 8 && sb.size() == 0); step++) begin
         out_ready = !(step >= 5 && step < 9);
         if (idx < 8) drive(bpa[idx], bpb[idx], bpc[idx], 1'b0);
         else         in_valid = 1'b0;
         #1;
         if (step >= 5 && step < 9) begin
            chk("bp_in_ready",  in_ready,  0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold", {cout, ovf, sum}, (sb.size() > 0) ? sb[0] : {(W+2){1'b1}});
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_count",    n_out - n0, 8);
      chk("bp_sb_empty", sb.size(),  0);

      // Reset with one result at the output and two more in flight.
      for (int i = 0; i < 3; i++) begin
         drive(16'h1111 * 16'(i + 1), 16'h0101, 1'b1, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      chk("mid_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_valid",    out_valid, 0);
      chk("mid_rst_sum",      sum,       0);
      chk("mid_rst_cout",     cout,      0);
      chk("mid_rst_ovf",      ovf,       0);
      chk("mid_rst_in_ready", in_ready,  1);
      tick();
      tick();
      chk("mid_rst_hold_valid", out_valid, 0);
      rst_n = 1'b1;
      tick();
      chk("post_mid_rst_valid", out_valid, 0);
      send_wait("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
      tick();
      chk("final_sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ks_pipe_adder.md
Name: ks_pipe_adder

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder.
- Generalises the team's fixed 4-bit combinational prefix adder to WIDTH bits, with carry-in, carry-out and signed overflow.
- Adds configurable pipeline registers between prefix levels and a valid/ready stream handshake with backpressure.
- Used as the arithmetic datapath core feeding downstream accumulate/compare blocks.

Parameters:
- WIDTH, 16, operand/sum width in bits; any value >= 2; prefix levels L = clog2(WIDTH).
- PIPE_EVERY, 2, register inserted after every PIPE_EVERY prefix levels; range 1..L.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  A+B+cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed two's-complement overflow: carry into MSB XOR cout.

Behaviour:
- Stage 0 (pre-process): g = a&b, p = a^b, with cin folded in as generate at position -1. Registered at the first pipeline boundary.
- Prefix level k (k = 0..L-1): span 2^k. Black cell: G = Gh | (Ph&Gl), P = Ph&Pl. Positions below the span pass through unchanged.
- A register follows every PIPE_EVERY levels. The last level's register is the output register.
- Post-process: sum[i] = p[i] ^ G[i-1], where G[-1] = cin. cout = G[WIDTH-1].
- Latency: LAT = 1 + ceil(L/PIPE_EVERY) cycles from accept to out_valid. With WIDTH=16 and PIPE_EVERY=2, LAT = 3.
- Each stage carries a valid bit.
- Global enable: adv = !out_valid || out_ready.
- in_ready = adv, a purely combinational function of out_valid and out_ready.
- Transfer at input: in_valid && in_ready. Transfer at output: out_valid && out_ready.
- When adv=1, every stage loads from its predecessor and stage-0 valid loads in_valid. When adv=0, all stages hold.
- Bubbles are not collapsed; throughput is 1 result/cycle with out_ready high.
- While out_valid=1 && out_ready=0, sum/cout/ovf/out_valid are held stable.
- Reset (asserted at any time, including mid-stream): all valid bits 0, sum=0, cout=0, ovf=0, out_valid=0. In-flight data is discarded. in_ready=1 during and after reset.
- Data registers may be reset or not, but outputs must read 0 while out_valid=0 after reset.
- Wrap-around: the sum is modulo 2^WIDTH. Carry appears only on cout; it is never lost or saturated.
- Simultaneous output drain and input accept in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro KS_ADD_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with a/b.
  - sub=1 computes a + ~b + 1, so cin is ignored and forced to 1. cout is the not-borrow. ovf is signed subtract overflow.
  - The mode travels with the data, so there is no cross-transaction leakage.
- Undefined: no sub port; add only, with cin honoured.

Decomposition:
- Package ks_pkg holds:
  - clog2 constant function;
  - level count L;
  - stage count NSTG = ceil(L/PIPE_EVERY);
  - function is_reg_level(k) returning 1 if a register follows level k.
- Sub-module ks_prefix_cell: black cell (G,P) combine, instantiated per position per level via generate.
- Grey cells (G only) are permitted for positions whose P is unused downstream.

Test Plan (WIDTH=16, PIPE_EVERY=2, LAT=3):
- Carry ripple: a=0xFFFF, b=0x0001, cin=0 -> 3 cycles later sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Streaming: 8 back-to-back random transactions with out_ready=1 -> 8 results on consecutive cycles starting at cycle 3, each matching the reference model.
- Backpressure: out_ready=0 for 4 cycles mid-stream -> in_ready=0 in those same cycles, output held constant, no loss or duplication of results.
- Reset mid-operation: assert rst_n=0 with 2 transactions in flight -> out_valid=0 and sum=0 immediately. After release, the first new result appears after exactly LAT cycles.
- KS_ADD_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
